time_digit_editor: RTL and testbench
====================================

Name: time_digit_editor

Overview:
- Holds a 24-hour HH:MM:SS time as six BCD digits.
- In RUN mode it advances the time on a 1 Hz enable pulse. In SET mode it edits one digit, chosen by a 3-bit digit-select index produced by the upstream digit-select FSM.
- It sits between that FSM and the seven-segment display mux. It consumes the FSM's `num`/`sel1` outputs, and its BCD bus and blink mask feed the display.

Parameters:
- INIT_H, default 0: hour loaded on reset. Range 0–23; out-of-range values are a configuration error.
- INIT_M, default 0: minute loaded on reset. Range 0–59.
- BLINK_DIV, default 25_000_000: clk cycles per blink phase. Minimum 2.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tick, input, 1: 1 Hz enable, one clk cycle wide.
- mode, input, 1: 1 = SET (edit), 0 = RUN (count).
- digit_sel, input, 3: digit index from the select FSM. 0=H tens, 1=H units, 2=M tens, 3=M units, 4=S tens, 5=S units.
- sel_valid, input, 1: qualifies digit_sel (driven by the FSM's sel1).
- inc, input, 1: debounced increment button, level.
- time_bcd, output, 24: {Ht,Hu,Mt,Mu,St,Su}, 4 bits each, Ht at [23:20].
- blink_mask, output, 6: bit i = 1 blanks digit i this phase. Bit 5 = Ht … bit 0 = Su.
- day_pulse, output, 1: one-cycle pulse on the 23:59:59 → 00:00:00 rollover in RUN.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - time = INIT_H:INIT_M:00.
  - state = RUN.
  - blink counter and phase = 0; inc edge register = 0.
  - blink_mask = 0; day_pulse = 0.
- State machine is two states, registered on clk:
  - RUN → SET when mode=1.
  - SET → RUN when mode=0.
  - The state change takes effect the cycle after mode changes; behaviour in a cycle follows the registered state.
- Increment edge detection: register inc_d; inc_pulse = inc & ~inc_d. Holding inc gives exactly one increment.
- RUN:
  - On tick=1, Su increments. Carries ripple: Su 9→0 carries to St; St 5→0 carries to Mu; Mu 9→0 carries to Mt; Mt 5→0 carries to hours.
  - Hours: Hu 9→0 carries to Ht. 23 → 00 (Ht=2 and Hu=3 both wrap to 0).
  - The whole update happens in one cycle, with no multi-cycle ripple.
  - day_pulse = 1 for exactly the cycle after the tick that produced 00:00:00.
  - inc_pulse is ignored.
- SET:
  - tick is ignored, so time is frozen.
  - On inc_pulse with sel_valid=1 and digit_sel ≤ 5, the selected digit increments modulo its range. There is no carry into neighbours.
  - Digit ranges: St and Mt 0–5; Su and Mu 0–9; Ht 0–2; Hu 0–9 when Ht<2, 0–3 when Ht=2.
  - If Ht becomes 2 while Hu>3, Hu is forced to 3 in the same cycle.
  - When Ht=2, a Hu increment wraps 3→0.
  - digit_sel = 6 or 7, or sel_valid=0: no edit.
  - Any edit to St or Su leaves the other digits unchanged.
- Blink:
  - A counter counts 0..BLINK_DIV-1. At the terminal count it wraps and toggles the phase.
  - In SET with sel_valid=1 and digit_sel ≤ 5: blink_mask = one-hot(digit_sel) while phase=1, else 0.
  - In RUN: blink_mask = 0 and the counter is held at 0.
- Simultaneous events:
  - tick in the same cycle as a RUN→SET mode change: the tick is applied (registered state is still RUN).
  - inc_pulse in the same cycle as a SET→RUN mode change: the edit is applied.
- Reset asserted mid-edit or mid-rollover: all state returns to the reset values immediately. No day_pulse is emitted.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset with INIT_H=12, INIT_M=34 → time_bcd=24'h123400, blink_mask=0, day_pulse=0. Assert reset_n low mid-count → returns to 24'h123400 asynchronously.
- RUN from 23:59:58, two ticks → 24'h235959 then 24'h000000. day_pulse high for one cycle only. Non-tick cycles leave time unchanged.
- SET, Ht=1, Hu=7, digit_sel=0, one inc press → Ht=2 and Hu clamped to 3 (24'h23xxxx). Press again → Ht=0, Hu stays 3.
- SET, digit_sel=4, St=5, hold inc for 10 cycles → St=0, exactly one increment, Mu unchanged. Ticks during SET → no change.
- SET, digit_sel=3, BLINK_DIV=4 → blink_mask toggles between 6'b000100 and 0 every 4 cycles. digit_sel=6 → blink_mask=0 and inc has no effect.
- tick coincident with mode 0→1 → one increment applied, then frozen. inc coincident with mode 1→0 → edit applied, then counting resumes.

Source files
------------

// File: rtl/time_digit_editor.sv
// HH:MM:SS BCD time keeper with per-digit SET editing and a blink mask for the
// digit currently chosen by the upstream digit-select FSM.
module time_digit_editor #(
  parameter int INIT_H    = 0,
  parameter int INIT_M    = 0,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        mode,
  input  logic [2:0]  digit_sel,
  input  logic        sel_valid,
  input  logic        inc,
  output logic [23:0] time_bcd,
  output logic [5:0]  blink_mask,
  output logic        day_pulse
);

  localparam int            CW       = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_DIV - 1);
  localparam logic [3:0]    RST_HT   = 4'(INIT_H / 10);
  localparam logic [3:0]    RST_HU   = 4'(INIT_H % 10);
  localparam logic [3:0]    RST_MT   = 4'(INIT_M / 10);
  localparam logic [3:0]    RST_MU   = 4'(INIT_M % 10);

  typedef enum logic {S_RUN, S_SET} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ht_q, hu_q, mt_q, mu_q, st_q, su_q;
  logic [3:0]    ht_d, hu_d, mt_d, mu_d, st_d, su_d;
  logic          inc_d_q, inc_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [5:0]    blink_mask_q, blink_mask_d;
  logic          day_pulse_q, day_pulse_d;

  logic inc_pulse, sel_ok;
  logic c_su, c_st, c_mu, c_mt;

  always_comb begin
    state_d      = mode ? S_SET : S_RUN;
    ht_d         = ht_q;
    hu_d         = hu_q;
    mt_d         = mt_q;
    mu_d         = mu_q;
    st_d         = st_q;
    su_d         = su_q;
    inc_d_d      = inc;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    day_pulse_d  = 1'b0;
    inc_pulse    = inc & ~inc_d_q;
    sel_ok       = sel_valid && (digit_sel <= 3'd5);
    c_su         = (su_q == 4'd9);
    c_st         = c_su && (st_q == 4'd5);
    c_mu         = c_st && (mu_q == 4'd9);
    c_mt         = c_mu && (mt_q == 4'd5);

    if (state_q == S_RUN) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      if (tick) begin
        // Whole carry chain resolves in one cycle.
        su_d = c_su ? 4'd0 : su_q + 4'd1;
        if (c_su) st_d = c_st ? 4'd0 : st_q + 4'd1;
        if (c_st) mu_d = c_mu ? 4'd0 : mu_q + 4'd1;
        if (c_mu) mt_d = c_mt ? 4'd0 : mt_q + 4'd1;
        if (c_mt) begin
          if (ht_q == 4'd2 && hu_q == 4'd3) begin
            ht_d        = 4'd0;
            hu_d        = 4'd0;
            day_pulse_d = 1'b1;
          end else if (hu_q == 4'd9) begin
            hu_d = 4'd0;
            ht_d = ht_q + 4'd1;
          end else begin
            hu_d = hu_q + 4'd1;
          end
        end
      end
    end else begin
      if (cnt_q == BLINK_TC) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (inc_pulse && sel_ok) begin
        case (digit_sel)
          3'd0: begin
            ht_d = (ht_q >= 4'd2) ? 4'd0 : ht_q + 4'd1;
            // Keep hours legal when tens reaches 2.
            if (ht_d == 4'd2 && hu_q > 4'd3) hu_d = 4'd3;
          end
          3'd1: begin
            if (ht_q == 4'd2) hu_d = (hu_q >= 4'd3) ? 4'd0 : hu_q + 4'd1;
            else              hu_d = (hu_q >= 4'd9) ? 4'd0 : hu_q + 4'd1;
          end
          3'd2:    mt_d = (mt_q >= 4'd5) ? 4'd0 : mt_q + 4'd1;
          3'd3:    mu_d = (mu_q >= 4'd9) ? 4'd0 : mu_q + 4'd1;
          3'd4:    st_d = (st_q >= 4'd5) ? 4'd0 : st_q + 4'd1;
          3'd5:    su_d = (su_q >= 4'd9) ? 4'd0 : su_q + 4'd1;
          default: ;
        endcase
      end
    end

    blink_mask_d = (state_q == S_SET && sel_ok && phase_d) ? (6'b100000 >> digit_sel) : 6'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      ht_q         <= RST_HT;
      hu_q         <= RST_HU;
      mt_q         <= RST_MT;
      mu_q         <= RST_MU;
      st_q         <= 4'd0;
      su_q         <= 4'd0;
      inc_d_q      <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      blink_mask_q <= 6'd0;
      day_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ht_q         <= ht_d;
      hu_q         <= hu_d;
      mt_q         <= mt_d;
      mu_q         <= mu_d;
      st_q         <= st_d;
      su_q         <= su_d;
      inc_d_q      <= inc_d_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      blink_mask_q <= blink_mask_d;
      day_pulse_q  <= day_pulse_d;
    end
  end

  assign time_bcd   = {ht_q, hu_q, mt_q, mu_q, st_q, su_q};
  assign blink_mask = blink_mask_q;
  assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_time_digit_editor.sv
// Scenario bench for time_digit_editor: expectations queued at drive time,
// popped and compared once the DUT has registered the result.
module tb_time_digit_editor;

  logic        clk, reset_n, tick, mode, sel_valid, inc;
  logic [2:0]  digit_sel;
  logic [23:0] time_bcd;
  logic [5:0]  blink_mask;
  logic        day_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_t[$];
  logic [5:0]  exp_m[$];
  logic        exp_d[$];

  time_digit_editor #(.INIT_H(12), .INIT_M(34), .BLINK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .mode(mode),
    .digit_sel(digit_sel), .sel_valid(sel_valid), .inc(inc),
    .time_bcd(time_bcd), .blink_mask(blink_mask), .day_pulse(day_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] s);
    digit_sel = s; sel_valid = 1'b1; inc = 1'b1;
    cyc();
    inc = 1'b0;
    cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e; logic [5:0] em; logic ed;
    reset_n = 1'b1; tick = 0; mode = 0; sel_valid = 0; inc = 0; digit_sel = 3'd0;
    #2 reset_n = 1'b0;
    exp_t.push_back(24'h123400); exp_m.push_back(6'd0); exp_d.push_back(1'b0);
    #1;
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL reset_time got %h want %h", time_bcd, e); end
    em = exp_m.pop_front(); n_tests++;
    if (blink_mask !== em) begin n_fail++; $display("FAIL reset_mask got %b want %b", blink_mask, em); end
    ed = exp_d.pop_front(); n_tests++;
    if (day_pulse !== ed) begin n_fail++; $display("FAIL reset_day got %b want %b", day_pulse, ed); end
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    repeat (3) pulse_tick();
    exp_t.push_back(24'h123403);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL run_count got %h want %h", time_bcd, e); end
    #3 reset_n = 1'b0;
    exp_t.push_back(24'h123400);
    #1;
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL async_reset got %h want %h", time_bcd, e); end
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_set_time();
    logic [23:0] e;
    mode = 1'b1;
    cyc();
    press(3'd0);
    exp_t.push_back(24'h223400);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL set_ht_no_clamp got %h want %h", time_bcd, e); end
    press(3'd1);
    repeat (2) press(3'd2);
    repeat (5) press(3'd3);
    repeat (5) press(3'd4);
    repeat (8) press(3'd5);
    exp_t.push_back(24'h235958);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL set_all_digits got %h want %h", time_bcd, e); end
  endtask

  task automatic test_rollover();
    logic [23:0] e; logic ed;
    mode = 1'b0; sel_valid = 1'b0;
    cyc();
    pulse_tick();
    exp_t.push_back(24'h235959); exp_d.push_back(1'b0);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL tick_59 got %h want %h", time_bcd, e); end
    ed = exp_d.pop_front(); n_tests++;
    if (day_pulse !== ed) begin n_fail++; $display("FAIL day_early got %b want %b", day_pulse, ed); end
    pulse_tick();
    exp_t.push_back(24'h000000); exp_d.push_back(1'b1);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL rollover got %h want %h", time_bcd, e); end
    ed = exp_d.pop_front(); n_tests++;
    if (day_pulse !== ed) begin n_fail++; $display("FAIL day_pulse got %b want %b", day_pulse, ed); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      exp_t.push_back(24'h000000); exp_d.push_back(1'b0);
      e = exp_t.pop_front(); n_tests++;
      if (time_bcd !== e) begin n_fail++; $display("FAIL idle_hold got %h want %h", time_bcd, e); end
      ed = exp_d.pop_front(); n_tests++;
      if (day_pulse !== ed) begin n_fail++; $display("FAIL day_one_cycle got %b want %b", day_pulse, ed); end
    end
  endtask

  task automatic test_hour_clamp();
    logic [23:0] e;
    mode = 1'b1;
    cyc();
    press(3'd0);
    repeat (7) press(3'd1);
    exp_t.push_back(24'h170000);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL set_17 got %h want %h", time_bcd, e); end
    press(3'd0);
    exp_t.push_back(24'h230000);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL hu_clamp got %h want %h", time_bcd, e); end
    press(3'd0);
    exp_t.push_back(24'h030000);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL ht_wrap got %h want %h", time_bcd, e); end
    press(3'd0); press(3'd0); press(3'd1);
    exp_t.push_back(24'h200000);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL hu_wrap_at_2 got %h want %h", time_bcd, e); end
  endtask

  task automatic test_hold_inc();
    logic [23:0] e;
    repeat (5) press(3'd4);
    press(3'd3);
    exp_t.push_back(24'h200150);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL set_st5 got %h want %h", time_bcd, e); end
    digit_sel = 3'd4; sel_valid = 1'b1; inc = 1'b1;
    repeat (10) cyc();
    inc = 1'b0;
    cyc();
    exp_t.push_back(24'h200100);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL hold_one_inc got %h want %h", time_bcd, e); end
    repeat (3) pulse_tick();
    exp_t.push_back(24'h200100);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL set_ignores_tick got %h want %h", time_bcd, e); end
  endtask

  task automatic test_blink();
    logic [23:0] e; logic [5:0] em;
    mode = 1'b0; sel_valid = 1'b0;
    repeat (3) cyc();
    exp_m.push_back(6'd0);
    em = exp_m.pop_front(); n_tests++;
    if (blink_mask !== em) begin n_fail++; $display("FAIL run_mask got %b want %b", blink_mask, em); end
    digit_sel = 3'd3; sel_valid = 1'b1; mode = 1'b1;
    for (int k = 1; k <= 16; k++)
      exp_m.push_back((((k - 1) / 4) % 2) != 0 ? 6'b000100 : 6'b000000);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      em = exp_m.pop_front(); n_tests++;
      if (blink_mask !== em) begin n_fail++; $display("FAIL blink_c%0d got %b want %b", k, blink_mask, em); end
    end
    digit_sel = 3'd6;
    cyc();
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp_m.push_back(6'd0);
      em = exp_m.pop_front(); n_tests++;
      if (blink_mask !== em) begin n_fail++; $display("FAIL sel6_mask got %b want %b", blink_mask, em); end
    end
    press(3'd6);
    digit_sel = 3'd2; sel_valid = 1'b0; inc = 1'b1;
    cyc();
    inc = 1'b0;
    cyc();
    exp_t.push_back(24'h200100);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL no_edit got %h want %h", time_bcd, e); end
  endtask

  task automatic test_coincident();
    logic [23:0] e;
    mode = 1'b0;
    cyc(); cyc();
    mode = 1'b1; tick = 1'b1;
    cyc();
    tick = 1'b0;
    exp_t.push_back(24'h200101);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL tick_at_set got %h want %h", time_bcd, e); end
    pulse_tick();
    exp_t.push_back(24'h200101);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL frozen got %h want %h", time_bcd, e); end
    digit_sel = 3'd5; sel_valid = 1'b1; inc = 1'b1; mode = 1'b0;
    cyc();
    inc = 1'b0;
    exp_t.push_back(24'h200102);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL inc_at_run got %h want %h", time_bcd, e); end
    pulse_tick();
    press(3'd5);
    exp_t.push_back(24'h200103);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL resume_run got %h want %h", time_bcd, e); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e; logic ed;
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    exp_t.push_back(24'h200106);
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL b2b_ticks got %h want %h", time_bcd, e); end
    #3 reset_n = 1'b0;
    exp_t.push_back(24'h123400); exp_d.push_back(1'b0);
    #1;
    e = exp_t.pop_front(); n_tests++;
    if (time_bcd !== e) begin n_fail++; $display("FAIL final_reset got %h want %h", time_bcd, e); end
    ed = exp_d.pop_front(); n_tests++;
    if (day_pulse !== ed) begin n_fail++; $display("FAIL final_reset_day got %b want %b", day_pulse, ed); end
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_rollover();
    test_hour_clamp();
    test_hold_inc();
    test_blink();
    test_coincident();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
